uart_byte_phy: RTL
==================

Name: uart_byte_phy

Overview:
- 8N1 UART serializer/deserializer that sits directly downstream of the Wishbone UART register block, on its passthrough-bridge side.
- Consumes single-cycle tx_valid byte pulses and drives the serial TX pin.
- Oversamples the serial RX pin and emits single-cycle rx_valid byte pulses back upstream.
- Used for the flight-controller / ESC serial passthrough link.

Parameters:
- CLK_FREQ_HZ, 72_000_000, system clock frequency.
- BAUD, 115200, line rate.
- OVERSAMPLE, 16, ticks per bit; must be even and >= 8.
- SYNC_STAGES, 2, RX input synchronizer depth.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to send; sampled on accept.
- tx_valid  in  1  send request; may be a single-cycle pulse.
- tx_ready  out  1  high when idle and able to accept a byte.
- rx_data  out  8  last received byte; held until the next good frame.
- rx_valid  out  1  one-cycle strobe for a good frame.
- rx_frame_err  out  1  one-cycle strobe for a bad stop bit.
- uart_rx_i  in  1  asynchronous serial input; idle high.
- uart_tx_o  out  1  serial output; idle high.
- uart_tx_oe  out  1  TX driver enable.

Behaviour:
- Clock and reset: clock clk; reset rst, synchronous, active-high.
- Reset values: uart_tx_o=1, tx_ready=1, rx_valid=0, rx_frame_err=0, rx_data=0x00, uart_tx_oe=1 (macro off), synchronizer flops=1.
- Reset mid-frame aborts both FSMs immediately; the line returns high on the next cycle.
- Divider: DIV = round(CLK_FREQ_HZ/(BAUD*OVERSAMPLE)), minimum 1 (39 at the defaults). One bit lasts exactly OVERSAMPLE*DIV clk cycles.
- TX accept: tx_valid && tx_ready in cycle N.
  - The byte is latched and tx_ready=0 from N+1.
  - uart_tx_o=0 (start bit) from N+1.
  - The TX divider is cleared on accept, so bit timing is deterministic.
  - tx_valid while tx_ready=0 is ignored; the upstream block must hold or re-issue it.
- TX FSM: IDLE -> START -> DATA (8 bits, LSB first, 3-bit index) -> STOP (line high for one bit time) -> IDLE.
  - tx_ready=1 in the cycle after STOP ends.
  - Accept-to-ready is 10*OVERSAMPLE*DIV cycles (6240 at the defaults).
  - Back-to-back frames therefore have no idle gap beyond one clk.
- RX input: uart_rx_i passes through SYNC_STAGES flops; all RX logic uses the synchronized value.
- RX FSM:
  - IDLE: a high-to-low transition clears the RX divider and the oversample counter; go to START.
  - START: sample at oversample count OVERSAMPLE/2-1. If high, treat as a glitch and return to IDLE with no strobe; otherwise go to DATA.
  - DATA: sample each bit at mid-bit, shift in LSB first; after 8 bits go to STOP.
  - STOP, mid-bit sample = 1: load rx_data and pulse rx_valid for one cycle; return to IDLE.
  - STOP, mid-bit sample = 0: pulse rx_frame_err for one cycle; rx_data is unchanged; go to BREAK.
  - BREAK: wait for a synchronized high, then go to IDLE. A held-low line produces exactly one error.
- rx_valid and rx_frame_err are never high together.
- TX and RX are fully independent, so simultaneous activity is allowed.
- No internal FIFO. Upstream overflow is the upstream block's concern.

Optional Feature:
- Macro UART_PHY_HALF_DUPLEX_EN (single-wire ESC mode).
- Defined:
  - uart_tx_oe=1 only from the TX START bit through the end of STOP plus one guard bit time; 0 otherwise, and 0 at reset.
  - RX forced to IDLE, ignoring edges, while uart_tx_oe=1. This suppresses echo.
  - tx_ready stays 0 through the guard bit.
- Undefined: uart_tx_oe tied to 1; full duplex; no guard bit.

Decomposition:
- Package uart_phy_pkg holds:
  - tx_state_t {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_GUARD};
  - rx_state_t {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK};
  - localparam DATA_BITS=8;
  - function calc_div(clk, baud, os).
- Sub-module uart_os_tick: DIV-cycle tick generator with a synchronous clear input, instantiated once for TX and once for RX.

Test Plan:
- Defaults, one-cycle tx_valid with tx_data=0xA5 -> uart_tx_o drops to 0 at N+1; line reads 0,1,0,1,0,0,1,0,1,1 at 624-cycle bit intervals; tx_ready returns at N+1+6240.
- Drive RX frame 0x3C at exact baud -> single rx_valid pulse with rx_data=0x3C, roughly 9.5 bit times after the start edge; no rx_frame_err.
- RX low glitch of 200 cycles (< half bit) -> no rx_valid, no rx_frame_err; an immediately following 0x55 frame is received correctly.
- RX frame 0x81 with stop bit 0, then line held low for 3 bit times -> exactly one rx_frame_err pulse; rx_data keeps its previous value; next good frame 0x42 is received.
- TX 0xFF while RX receives 0x00, with +/-3% RX baud error -> both complete correctly.
- Reset asserted mid-DATA on TX and RX -> next cycle uart_tx_o=1, tx_ready=1, no strobes.
- Half-duplex macro defined: the TX frame's own bits looped back to RX -> no rx_valid; uart_tx_oe low exactly one bit time after STOP.

Source files
------------

// File: rtl/uart_phy_pkg.sv
// uart_phy_pkg: shared FSM encodings and baud divider helper for uart_byte_phy.
// Build with UART_PHY_HALF_DUPLEX_EN to enable the TX guard-bit state.
package uart_phy_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_GUARD
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  localparam int DATA_BITS = 8;

  // Rounded clk/(baud*os), never below one cycle per tick.
  function automatic int calc_div(
    input int clk_hz,
    input int baud,
    input int os
  );
    longint den;
    longint q;
    den = longint'(baud) * longint'(os);
    q   = (longint'(clk_hz) + den / 2) / den;
    return (q < 1) ? 1 : int'(q);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// uart_os_tick: one-cycle tick every DIV clocks, restarted by a synchronous clear.
// Shared by the TX and RX halves of uart_byte_phy.
module uart_os_tick #(
  parameter int DIV = 39
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_byte_phy.sv
// uart_byte_phy: 8N1 UART serializer/deserializer for the FC/ESC passthrough link.
// Define UART_PHY_HALF_DUPLEX_EN for single-wire mode (TX guard bit, RX echo mute).
module uart_byte_phy
  import uart_phy_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 72_000_000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  input  logic       uart_rx_i,
  output logic       uart_tx_o,
  output logic       uart_tx_oe
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

  tx_state_t      tx_state, tx_next;
  logic [OSW-1:0] tx_os, tx_os_next;
  logic [2:0]     tx_idx, tx_idx_next;
  logic [7:0]     tx_byte;
  logic           tx_tick, tx_bit_end, tx_accept, tx_line_next;

  assign tx_ready   = (tx_state == TX_IDLE);
  assign tx_accept  = tx_valid && tx_ready;
  assign tx_bit_end = tx_tick && (tx_os == OS_LAST);

  uart_os_tick #(.DIV(DIV)) u_tx_tick (
    .clk (clk),
    .rst (rst),
    .clr (tx_state == TX_IDLE),
    .tick(tx_tick)
  );

  always_comb begin
    tx_next     = tx_state;
    tx_idx_next = tx_idx;
    tx_os_next  = tx_os;
    if (tx_tick) begin
      tx_os_next = (tx_os == OS_LAST) ? '0 : tx_os + 1'b1;
    end
    unique case (tx_state)
      TX_IDLE: begin
        tx_os_next  = '0;
        tx_idx_next = '0;
        if (tx_valid) tx_next = TX_START;
      end
      TX_START: begin
        if (tx_bit_end) tx_next = TX_DATA;
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_idx_next = tx_idx + 1'b1;
          if (tx_idx == IDX_LAST) tx_next = TX_STOP;
        end
      end
      TX_STOP: begin
`ifdef UART_PHY_HALF_DUPLEX_EN
        if (tx_bit_end) tx_next = TX_GUARD;
`else
        if (tx_bit_end) tx_next = TX_IDLE;
`endif
      end
      TX_GUARD: begin
        if (tx_bit_end) tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // The pin is driven from a flop so it never glitches between bits.
  always_comb begin
    tx_line_next = 1'b1;
    unique case (tx_next)
      TX_START: tx_line_next = 1'b0;
      TX_DATA:  tx_line_next = tx_byte[tx_idx_next];
      default:  tx_line_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_os     <= '0;
      tx_idx    <= '0;
      tx_byte   <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      tx_state  <= tx_next;
      tx_os     <= tx_os_next;
      tx_idx    <= tx_idx_next;
      uart_tx_o <= tx_line_next;
      if (tx_accept) tx_byte <= tx_data;
    end
  end

`ifdef UART_PHY_HALF_DUPLEX_EN
  logic tx_oe;

  always_ff @(posedge clk) begin
    if (rst) tx_oe <= 1'b0;
    else     tx_oe <= (tx_next != TX_IDLE);
  end

  assign uart_tx_oe = tx_oe;
`else
  assign uart_tx_oe = 1'b1;
`endif

  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_s, rx_prev;
  rx_state_t              rx_state, rx_next;
  logic [OSW-1:0]         rx_os, rx_os_next;
  logic [2:0]             rx_idx, rx_idx_next;
  logic [7:0]             rx_shift, rx_shift_next;
  logic [7:0]             rx_data_next;
  logic                   rx_valid_next, rx_err_next;
  logic                   rx_tick, rx_sample;

  assign rx_s      = rx_sync[SYNC_STAGES-1];
  assign rx_sample = rx_tick && (rx_os == OS_LAST);

  uart_os_tick #(.DIV(DIV)) u_rx_tick (
    .clk (clk),
    .rst (rst),
    .clr (rx_state == RX_IDLE),
    .tick(rx_tick)
  );

  // After the start-bit mid sample the count restarts, so every later
  // sample lands one full bit later, i.e. mid-bit.
  always_comb begin
    rx_next       = rx_state;
    rx_os_next    = rx_os;
    rx_idx_next   = rx_idx;
    rx_shift_next = rx_shift;
    rx_data_next  = rx_data;
    rx_valid_next = 1'b0;
    rx_err_next   = 1'b0;
    if (rx_tick) rx_os_next = rx_os + 1'b1;
    unique case (rx_state)
      RX_IDLE: begin
        rx_os_next  = '0;
        rx_idx_next = '0;
        if (rx_prev && !rx_s) rx_next = RX_START;
      end
      RX_START: begin
        if (rx_tick && (rx_os == OS_MID)) begin
          rx_os_next = '0;
          rx_next    = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_os_next    = '0;
          rx_shift_next = {rx_s, rx_shift[7:1]};
          rx_idx_next   = rx_idx + 1'b1;
          if (rx_idx == IDX_LAST) rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          rx_os_next = '0;
          if (rx_s) begin
            rx_data_next  = rx_shift;
            rx_valid_next = 1'b1;
            rx_next       = RX_IDLE;
          end else begin
            rx_err_next = 1'b1;
            rx_next     = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        if (rx_s) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
`ifdef UART_PHY_HALF_DUPLEX_EN
    if (tx_oe) begin
      rx_next       = RX_IDLE;
      rx_data_next  = rx_data;
      rx_valid_next = 1'b0;
      rx_err_next   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync      <= '1;
      rx_prev      <= 1'b1;
      rx_state     <= RX_IDLE;
      rx_os        <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_sync      <= (rx_sync << 1) | SYNC_STAGES'(uart_rx_i);
      rx_prev      <= rx_s;
      rx_state     <= rx_next;
      rx_os        <= rx_os_next;
      rx_idx       <= rx_idx_next;
      rx_shift     <= rx_shift_next;
      rx_data      <= rx_data_next;
      rx_valid     <= rx_valid_next;
      rx_frame_err <= rx_err_next;
    end
  end

endmodule
